// File: rtl/gf_inverse_seq.sv
// gf_inverse_seq: sequential GF(2^8) inverse (x^254 mod 0x11B) by square-and-multiply over 13 cycles
//   clk, rst               : clock, asynchronous active-high reset
//   in_valid/in_ready      : input handshake for byte_in and encrypt tag
//   out_valid/out_ready    : output handshake for byte_out and encrypt_out (both 0 when idle)
//   busy                   : high while calculating or holding a result
module gf_inverse_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] byte_in,
  input  logic       encrypt,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] byte_out,
  output logic       encrypt_out,
  output logic       busy
);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [7:0] acc_q, acc_d, base_q, base_d;
  logic [3:0] step_q, step_d;
  logic       tag_q, tag_d;
  logic       accept, calc;
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) p = p ^ (b[i] ? ({7'b0, a} << i) : 15'd0);
    for (int i = 14; i >= 8; i--) p = p ^ (p[i] ? (15'h11B << (i - 8)) : 15'd0);
    return p[7:0];
  endfunction
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  // even steps square, odd steps multiply by the original byte
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc_q  <= '0;
      base_q <= '0;
      step_q <= '0;
      tag_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      base_q <= base_d;
      step_q <= step_d;
      tag_q  <= tag_d;
    end
  always_comb begin
    accept  = in_valid & in_ready;
    calc    = state_q == CALC;
    state_d = (state_q == IDLE) ? (accept ? CALC : IDLE)
            : calc ? ((step_q == 4'd12) ? DONE : (step_q > 4'd12) ? IDLE : CALC)
            : (state_q == DONE) ? (out_ready ? IDLE : DONE)
            : IDLE;
    acc_d   = accept ? byte_in : calc ? gf_mul(acc_q, step_q[0] ? base_q : acc_q) : acc_q;
    base_d  = accept ? byte_in : base_q;
    tag_d   = accept ? encrypt : tag_q;
    step_d  = accept ? 4'd0 : calc ? step_q + 4'd1 : step_q;
  end
  always_comb begin
    in_ready    = (state_q == IDLE) & ~rst;
    out_valid   = state_q == DONE;
    busy        = state_q != IDLE;
    byte_out    = out_valid ? acc_q : 8'd0;
    encrypt_out = out_valid & tag_q;
  end
endmodule

// File: tb/tb_gf_inverse_seq.sv
// tb_gf_inverse_seq: directed and exhaustive self-checking bench for gf_inverse_seq
module tb_gf_inverse_seq;
  logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, encrypt = 1'b0, out_ready = 1'b0;
  logic [7:0] byte_in = '0;
  logic       in_ready, out_valid, encrypt_out, busy;
  logic [7:0] byte_out;
  int n_tests = 0, n_fail = 0, cyc = 0, acc_cyc = 0, prev_acc = 0, lat = 0, spur = 0;
  logic [7:0] got_b, ia;
  logic       got_t;
  gf_inverse_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .byte_in(byte_in),
    .encrypt(encrypt), .out_valid(out_valid), .out_ready(out_ready), .byte_out(byte_out),
    .encrypt_out(encrypt_out), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, t;
    r = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1B : 8'h00);
    end
    return r;
  endfunction
  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
    return r ^ 8'h05;
  endfunction
  task automatic accept(input logic [7:0] b, input logic e);
    int k = 0;
    byte_in = b;
    encrypt = e;
    in_valid = 1'b1;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("accept_timeout", {31'b0, in_ready}, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    prev_acc = acc_cyc;
    acc_cyc = cyc;
  endtask
  task automatic wait_out(output logic [7:0] b, output logic t);
    int k = 0;
    while (!out_valid && k < 40) begin
      chk("gate", {23'b0, encrypt_out, byte_out}, 0);
      @(posedge clk); #1;
      k++;
    end
    chk("out_timeout", {31'b0, out_valid}, 1);
    lat = cyc - acc_cyc;
    b = byte_out;
    t = encrypt_out;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {in_ready, out_valid, busy, encrypt_out, byte_out}, 0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    out_ready = 1'b1;
    accept(8'h53, 1'b0);
    wait_out(got_b, got_t);
    chk("lat_53", lat, 13);
    chk("inv_53", got_b, 8'hCA);
    chk("tag_53", got_t, 0);
    chk("busy_done", {31'b0, busy}, 1);
    @(posedge clk); #1;
    chk("ready_after", {in_ready, out_valid, byte_out}, {2'b10, 8'h00});
    for (int i = 0; i < 4; i++) begin
      logic [7:0] x, exp_v;
      x = 8'(i);
      exp_v = (i == 0) ? 8'h00 : (i == 1) ? 8'h01 : (i == 2) ? 8'h8D : 8'hF6;
      accept(x, 1'b0);
      if (i > 0) chk("b2b_spacing", acc_cyc - prev_acc, 15);
      wait_out(got_b, got_t);
      chk("b2b_inv", got_b, exp_v);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    accept(8'h02, 1'b1);
    wait_out(got_b, got_t);
    chk("bp_first", {got_t, got_b}, {1'b1, 8'h8D});
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      byte_in = 8'h77;
      encrypt = 1'b0;
      @(posedge clk); #1;
      chk("bp_hold", {in_ready, out_valid, encrypt_out, byte_out}, {3'b011, 8'h8D});
    end
    in_valid = 1'b1;
    byte_in = 8'h03;
    encrypt = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hs_no_accept", {busy, in_ready, out_valid}, 3'b010);
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_cyc = cyc;
    chk("hs_next_accept", {31'b0, busy}, 1);
    wait_out(got_b, got_t);
    chk("hs_inv_03", got_b, 8'hF6);
    chk("hs_lat", lat, 13);
    @(posedge clk); #1;
    accept(8'h53, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_outs", {in_ready, out_valid, busy, encrypt_out, byte_out}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    spur = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) spur++;
    end
    chk("abort_spurious", spur, 0);
    accept(8'h03, 1'b0);
    wait_out(got_b, got_t);
    chk("abort_inv_03", got_b, 8'hF6);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int x = 0; x < 256; x++) begin
      logic e;
      int h;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      e = 1'($urandom_range(0, 1));
      accept(8'(x), e);
      wait_out(got_b, got_t);
      h = $urandom_range(0, 3);
      for (int j = 0; j < h; j++) begin
        @(posedge clk); #1;
        chk("sweep_stable", {23'b0, encrypt_out, byte_out}, {23'b0, got_t, got_b});
      end
      if (x == 0) chk("sweep_zero", got_b, 8'h00);
      else chk("sweep_inv", ref_mul(8'(x), got_b), 8'h01);
      chk("sweep_tag", {31'b0, got_t}, {31'b0, e});
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("sweep_gate", {23'b0, out_valid, byte_out}, 0);
    end
    out_ready = 1'b1;
    ia = inv_affine(8'hED);
    accept(ia, 1'b0);
    wait_out(got_b, got_t);
    chk("chain_invsbox", got_b, 8'h53);
    chk("chain_tag", {31'b0, got_t}, 0);
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
